// File: rtl/beat_sequencer_if.sv
// Control and status bundle between a playback controller and beat_sequencer.
// The seek pulses exist only when BEAT_SEQ_SEEK_EN is defined.
interface beat_sequencer_if;
    logic        play;
    logic        pause;
    logic        stop;
    logic        loop_en;
    logic [1:0]  tempo;
`ifdef BEAT_SEQ_SEEK_EN
    logic        seek_fwd;
    logic        seek_back;
`endif
    logic [11:0] ibeatNum;
    logic        en;
    logic        beat_tick;
    logic        done;
    logic [1:0]  state;

`ifdef BEAT_SEQ_SEEK_EN
    modport master (
        output play, pause, stop, loop_en, tempo, seek_fwd, seek_back,
        input  ibeatNum, en, beat_tick, done, state
    );
    modport slave (
        input  play, pause, stop, loop_en, tempo, seek_fwd, seek_back,
        output ibeatNum, en, beat_tick, done, state
    );
`else
    modport master (
        output play, pause, stop, loop_en, tempo,
        input  ibeatNum, en, beat_tick, done, state
    );
    modport slave (
        input  play, pause, stop, loop_en, tempo,
        output ibeatNum, en, beat_tick, done, state
    );
`endif
endinterface

// File: rtl/beat_sequencer.sv
// beat_sequencer: divides clk down to a beat rate (tempo selectable) and runs
// an IDLE/PLAY/PAUSE machine that produces the beat index and play enable for
// the tone lookup stage. Optional feature macro: BEAT_SEQ_SEEK_EN adds
// note-granular (4-beat) seek forward/back.
module beat_sequencer #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned BEAT_HZ = 8,
    parameter int unsigned LEN     = 64
) (
    input  logic              clk,
    input  logic              rst,
    beat_sequencer_if.slave   bus
);
    localparam int unsigned DIV      = CLK_HZ / BEAT_HZ;
    localparam logic [31:0] P_1X     = 32'(DIV);
    localparam logic [31:0] P_2X     = 32'(DIV / 2);
    localparam logic [31:0] P_HALF   = 32'(2 * DIV);
    localparam logic [11:0] LAST     = 12'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [11:0] beat_q,   beat_d;
    logic [31:0] presc_q,  presc_d;
    logic [31:0] period_q, period_d;
    logic        tick_q,   tick_d;
    logic        done_q,   done_d;

    // Beat period selected by the tempo code; 11 is treated as 1x.
    function automatic logic [31:0] period_of(input logic [1:0] t);
        case (t)
            2'b01:   return P_2X;
            2'b10:   return P_HALF;
            default: return P_1X;
        endcase
    endfunction

    logic terminal;
    assign terminal = (presc_q == period_q - 32'd1);

`ifdef BEAT_SEQ_SEEK_EN
    localparam logic [11:0] SEEK_MAX = 12'(LEN - 4);
    logic        seek_go;
    logic [11:0] seek_target;
    logic [11:0] seek_base;

    // Seek target snaps to the current note start, then moves one note,
    // clamped to the first/last note. Conflicting seeks cancel.
    always_comb begin
        seek_base   = {beat_q[11:2], 2'b00};
        seek_go     = bus.seek_fwd ^ bus.seek_back;
        seek_target = seek_base;
        if (bus.seek_fwd) begin
            if ({1'b0, seek_base} + 13'd4 > {1'b0, SEEK_MAX})
                seek_target = SEEK_MAX;
            else
                seek_target = seek_base + 12'd4;
        end else if (seek_base != 12'd0) begin
            seek_target = seek_base - 12'd4;
        end
    end
`else
    logic        seek_go;
    logic [11:0] seek_target;
    assign seek_go     = 1'b0;
    assign seek_target = 12'd0;
`endif

    // Next-state, prescaler and beat-index logic; stop > pause > seek > tick.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        presc_d  = presc_q;
        period_d = period_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.play && !bus.pause && !bus.stop) begin
                    state_d  = PLAY;
                    beat_d   = 12'd0;
                    presc_d  = 32'd0;
                    period_d = period_of(bus.tempo);
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    beat_d  = 12'd0;
                    presc_d = 32'd0;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else if (seek_go) begin
                    beat_d  = seek_target;
                    presc_d = 32'd0;
                end else if (terminal) begin
                    presc_d  = 32'd0;
                    tick_d   = 1'b1;
                    period_d = period_of(bus.tempo);
                    if (beat_q == LAST) begin
                        beat_d = 12'd0;
                        if (!bus.loop_en) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 12'd1;
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    beat_d  = 12'd0;
                    presc_d = 32'd0;
                end else if (seek_go) begin
                    beat_d  = seek_target;
                    presc_d = 32'd0;
                end else if (bus.play && !bus.pause) begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 12'd0;
                presc_d = 32'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 12'd0;
            presc_q  <= 32'd0;
            period_q <= P_1X;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            presc_q  <= presc_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign bus.ibeatNum  = beat_q;
    assign bus.en        = (state_q == PLAY);
    assign bus.beat_tick = tick_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with DIV=4, LEN=8.
module tb_beat_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    beat_sequencer_if bif();

    beat_sequencer #(.CLK_HZ(16), .BEAT_HZ(4), .LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_play();
        bif.play = 1'b1;
        step();
        bif.play = 1'b0;
    endtask

    task automatic go_stop();
        bif.stop = 1'b1;
        step();
        bif.stop = 1'b0;
    endtask

    initial begin
        int dones;
        bif.play = 0; bif.pause = 0; bif.stop = 0; bif.loop_en = 0; bif.tempo = 2'b00;
`ifdef BEAT_SEQ_SEEK_EN
        bif.seek_fwd = 0; bif.seek_back = 0;
`endif
        // Reset
        rst = 1'b1;
        repeat (3) step();
        $display("phase reset");
        check("rst_beat",  32'(bif.ibeatNum), 32'd0);
        check("rst_en",    32'(bif.en),       32'd0);
        check("rst_tick",  32'(bif.beat_tick),32'd0);
        check("rst_done",  32'(bif.done),     32'd0);
        check("rst_state", 32'(bif.state),    32'd0);
        rst = 1'b0;
        step();
        bif.pause = 1'b1; step(); bif.pause = 1'b0;
        check("idle_pause_state", 32'(bif.state), 32'd0);
        go_stop();
        check("idle_stop_state", 32'(bif.state), 32'd0);
        check("idle_stop_beat",  32'(bif.ibeatNum), 32'd0);

        // Single play, no loop
        $display("phase single play");
        go_play();
        check("start_en",    32'(bif.en),       32'd1);
        check("start_state", 32'(bif.state),    32'd1);
        check("start_beat",  32'(bif.ibeatNum), 32'd0);
        dones = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (bif.done) dones++;
            check("run_tick", 32'(bif.beat_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k < 32) begin
                check("run_beat", 32'(bif.ibeatNum), 32'(k / 4));
                check("run_en",   32'(bif.en),       32'd1);
            end
        end
        check("end_done",  32'(bif.done),     32'd1);
        check("end_beat",  32'(bif.ibeatNum), 32'd0);
        check("end_en",    32'(bif.en),       32'd0);
        check("end_state", 32'(bif.state),    32'd0);
        step();
        if (bif.done) dones++;
        check("done_count", 32'(dones), 32'd1);

        // Loop for three passes
        $display("phase loop");
        bif.loop_en = 1'b1;
        go_play();
        dones = 0;
        for (int k = 1; k <= 96; k++) begin
            step();
            if (bif.done) dones++;
            check("loop_beat", 32'(bif.ibeatNum), 32'((k / 4) % 8));
            check("loop_en",   32'(bif.en),       32'd1);
        end
        check("loop_done_count", 32'(dones), 32'd0);
        go_stop();
        check("loop_stop_state", 32'(bif.state), 32'd0);
        bif.loop_en = 1'b0;

        // Pause two cycles into beat 3
        $display("phase pause");
        go_play();
        repeat (14) step();
        check("pre_pause_beat", 32'(bif.ibeatNum), 32'd3);
        bif.pause = 1'b1; step(); bif.pause = 1'b0;
        check("pause_state", 32'(bif.state), 32'd2);
        check("pause_en",    32'(bif.en),    32'd0);
        repeat (10) step();
        check("paused_beat", 32'(bif.ibeatNum), 32'd3);
        check("paused_en",   32'(bif.en),       32'd0);
        go_play();
        check("resume_state", 32'(bif.state),    32'd1);
        check("resume_beat0", 32'(bif.ibeatNum), 32'd3);
        step();
        check("resume_beat1", 32'(bif.ibeatNum), 32'd3);
        step();
        check("resume_beat2", 32'(bif.ibeatNum), 32'd4);
        check("resume_tick",  32'(bif.beat_tick),32'd1);
        go_stop();

        // Tempo changes
        $display("phase tempo");
        go_play();
        repeat (9) step();
        bif.tempo = 2'b01;
        repeat (2) step();
        check("tempo_k11", 32'(bif.ibeatNum), 32'd2);
        step();
        check("tempo_k12", 32'(bif.ibeatNum), 32'd3);
        repeat (2) step();
        check("tempo_k14", 32'(bif.ibeatNum), 32'd4);
        step();
        bif.tempo = 2'b10;
        step();
        check("tempo_k16", 32'(bif.ibeatNum), 32'd5);
        repeat (7) step();
        check("tempo_k23", 32'(bif.ibeatNum), 32'd5);
        step();
        check("tempo_k24", 32'(bif.ibeatNum), 32'd6);
        go_stop();
        bif.tempo = 2'b00;

        // Simultaneous control pulses
        $display("phase priority");
        go_play();
        repeat (8) step();
        check("prio_pre_beat", 32'(bif.ibeatNum), 32'd2);
        bif.stop = 1'b1; bif.pause = 1'b1; bif.play = 1'b1;
        step();
        bif.stop = 1'b0; bif.pause = 1'b0; bif.play = 1'b0;
        check("prio_state", 32'(bif.state),    32'd0);
        check("prio_beat",  32'(bif.ibeatNum), 32'd0);

`ifdef BEAT_SEQ_SEEK_EN
        $display("phase seek");
        go_play();
        repeat (20) step();
        check("seek_pre_beat", 32'(bif.ibeatNum), 32'd5);
        bif.seek_fwd = 1'b1; step(); bif.seek_fwd = 1'b0;
        check("seek_fwd_beat",  32'(bif.ibeatNum), 32'd4);
        check("seek_fwd_state", 32'(bif.state),    32'd1);
        check("seek_fwd_tick",  32'(bif.beat_tick),32'd0);
        bif.seek_back = 1'b1; step(); bif.seek_back = 1'b0;
        check("seek_back_beat", 32'(bif.ibeatNum), 32'd0);
        repeat (3) step();
        check("seek_presc_a", 32'(bif.ibeatNum), 32'd0);
        step();
        check("seek_presc_b", 32'(bif.ibeatNum), 32'd1);
        go_stop();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
